// File: rtl/axi_stream_rr_arbiter.sv
// Packet-aware round-robin arbiter: one AXI-Stream source at a time is granted
// until its tlast beat is accepted; beats leave through one registered stage tagged with the source index.
//
// state  | meaning
// IDLE   | no grant held; picks the next requester starting at ptr_r
// LOCKED | grant_r owns the output until its tlast beat is accepted
module axi_stream_rr_arbiter #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 2,
   parameter int ADDR_NUM   = 1 << ADDR_WIDTH
) (
   input  logic                  aclk_i,
   input  logic                  areset_i,
   input  logic [DATA_WIDTH-1:0] tdata_i [0:ADDR_NUM-1],
   input  logic [ADDR_NUM-1:0]   tlast_i,
   input  logic [ADDR_NUM-1:0]   tvalid_i,
   output logic [ADDR_NUM-1:0]   tready_o,
   output logic [DATA_WIDTH-1:0] tdata_o,
   output logic                  tlast_o,
   output logic [ADDR_WIDTH-1:0] taddr_o,
   output logic                  tvalid_o,
   input  logic                  tready_i,
   output logic                  locked_o
);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] grant_r;
   logic [ADDR_WIDTH-1:0] ptr_r;
   logic [ADDR_WIDTH-1:0] next_grant;
   logic [ADDR_NUM-1:0]   tready_w;
   logic                  accept;

   // Search order ptr_r, ptr_r+1, ... wraps through ADDR_WIDTH overflow.
   always_comb begin
      logic [ADDR_WIDTH-1:0] idx;
      logic                  found;
      next_grant = ptr_r;
      found      = 1'b0;
      idx        = ptr_r;
      for (int k = 0; k < ADDR_NUM; k++) begin
         idx = ptr_r + ADDR_WIDTH'(k);
         if (!found && tvalid_i[idx]) begin
            next_grant = idx;
            found      = 1'b1;
         end
      end
   end

   // The output register may only be overwritten once it is empty or draining.
   always_comb begin
      tready_w = '0;
      if (state == LOCKED) begin
         tready_w[grant_r] = ~tvalid_o | tready_i;
      end
   end

   assign tready_o = tready_w;
   assign accept   = tvalid_i[grant_r] & tready_w[grant_r];
   assign locked_o = (state == LOCKED);

   always_ff @(posedge aclk_i) begin
      if (areset_i) begin
         state    <= IDLE;
         grant_r  <= '0;
         ptr_r    <= '0;
         tvalid_o <= 1'b0;
         tdata_o  <= '0;
         tlast_o  <= 1'b0;
         taddr_o  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|tvalid_i) begin
                  grant_r <= next_grant;
                  state   <= LOCKED;
               end
            end
            LOCKED: begin
               if (accept && tlast_i[grant_r]) begin
                  state <= IDLE;
                  ptr_r <= grant_r + ADDR_WIDTH'(1);
               end
            end
            default: state <= IDLE;
         endcase

         if (accept) begin
            tdata_o  <= tdata_i[grant_r];
            tlast_o  <= tlast_i[grant_r];
            taddr_o  <= grant_r;
            tvalid_o <= 1'b1;
         end else if (tvalid_o && tready_i) begin
            tvalid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_axi_stream_rr_arbiter.sv
// Scoreboard bench for axi_stream_rr_arbiter: per-source beat queues plus an
// expected grant order; a negedge monitor checks every output transfer.
module tb_axi_stream_rr_arbiter;
   localparam int DW = 16;
   localparam int AW = 2;
   localparam int N  = 4;

   logic          clk = 1'b0;
   logic          areset_i;
   logic [DW-1:0] tdata_i [0:N-1];
   logic [N-1:0]  tlast_i;
   logic [N-1:0]  tvalid_i;
   logic [N-1:0]  tready_o;
   logic [DW-1:0] tdata_o;
   logic          tlast_o;
   logic [AW-1:0] taddr_o;
   logic          tvalid_o;
   logic          tready_i;
   logic          locked_o;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   beat_t src_q [N][$];
   beat_t exp_q [N][$];
   int    ord_q [$];
   int    n_chk = 0;
   int    n_fail = 0;
   logic  rand_in = 1'b1;
   int    bubble_pct = 0;
   logic [N-1:0] take = '0;

   axi_stream_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .aclk_i(clk), .areset_i(areset_i), .tdata_i(tdata_i), .tlast_i(tlast_i),
      .tvalid_i(tvalid_i), .tready_o(tready_o), .tdata_o(tdata_o), .tlast_o(tlast_o),
      .taddr_o(taddr_o), .tvalid_o(tvalid_o), .tready_i(tready_i), .locked_o(locked_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: event not seen within cycle budget", name);
   endtask

   task automatic push_beat(input int s, input int data, input logic last);
      beat_t b;
      b.data = DW'(data);
      b.last = last;
      src_q[s].push_back(b);
      exp_q[s].push_back(b);
   endtask

   task automatic push_pkt(input int s, input int len, input int base);
      for (int i = 0; i < len; i++) push_beat(s, base + i, i == len - 1);
   endtask

   task automatic clear_all();
      for (int s = 0; s < N; s++) begin
         src_q[s].delete();
         exp_q[s].delete();
      end
      ord_q.delete();
   endtask

   function automatic logic idle_all();
      for (int s = 0; s < N; s++)
         if (src_q[s].size() != 0 || exp_q[s].size() != 0) return 1'b0;
      return !tvalid_o && !locked_o && ord_q.size() == 0;
   endfunction

   task automatic drain(input int limit);
      for (int i = 0; i < limit; i++) begin
         @(posedge clk); #3;
         if (idle_all()) return;
      end
      fail("drain_timeout");
   endtask

   task automatic do_reset(input int ncyc);
      @(posedge clk); #3;
      areset_i = 1'b1;
      clear_all();
      repeat (ncyc) @(posedge clk);
      #3;
      areset_i = 1'b0;
   endtask

   // Source drivers: hold a beat until it is taken, optional bubbles between beats.
   always @(negedge clk) take = tvalid_i & tready_o & {N{~areset_i}};

   always @(posedge clk) begin
      #1;
      for (int s = 0; s < N; s++) begin
         if (take[s] && src_q[s].size() > 0) void'(src_q[s].pop_front());
         if (rand_in) begin
            tvalid_i[s] = 1'($urandom_range(1));
            tlast_i[s]  = 1'($urandom_range(1));
            tdata_i[s]  = DW'($urandom);
         end else if (src_q[s].size() == 0) begin
            tvalid_i[s] = 1'b0;
            tlast_i[s]  = 1'b0;
         end else begin
            if (!tvalid_i[s] || take[s]) tvalid_i[s] = ($urandom_range(99) >= bubble_pct);
            tdata_i[s] = src_q[s][0].data;
            tlast_i[s] = src_q[s][0].last;
         end
      end
   end

   // Monitor: scoreboard pops, packet atomicity, grant order, stall stability.
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data;
   logic          prev_last;
   logic [AW-1:0] prev_addr;
   logic          in_pkt = 1'b0;
   logic [AW-1:0] cur_src;

   always @(negedge clk) begin : monitor
      beat_t b;
      int    s;
      if (areset_i) begin
         in_pkt     = 1'b0;
         prev_stall = 1'b0;
      end else begin
         check("tready_onehot", 32'($countones(tready_o) <= 1), 32'(1));
         if (prev_stall) begin
            check("stall_valid", 32'(tvalid_o), 32'(1));
            check("stall_data", 32'(tdata_o), 32'(prev_data));
            check("stall_last", 32'(tlast_o), 32'(prev_last));
            check("stall_addr", 32'(taddr_o), 32'(prev_addr));
         end
         if (tvalid_o && !tready_i) check("stall_tready", 32'(tready_o), 32'(0));
         if (tvalid_o && tready_i) begin
            s = int'(taddr_o);
            if (exp_q[s].size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_beat: src %0d data %0h, none expected", s, tdata_o);
            end else begin
               b = exp_q[s].pop_front();
               check("beat_data", 32'(tdata_o), 32'(b.data));
               check("beat_last", 32'(tlast_o), 32'(b.last));
            end
            if (in_pkt) check("pkt_atomic", 32'(taddr_o), 32'(cur_src));
            else if (ord_q.size() > 0) check("grant_order", 32'(taddr_o), 32'(ord_q.pop_front()));
            in_pkt  = !tlast_o;
            cur_src = taddr_o;
         end
         prev_stall = tvalid_o && !tready_i;
         prev_data  = tdata_o;
         prev_last  = tlast_o;
         prev_addr  = taddr_o;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int   sp_v [6] = '{0, 0, 1, 1, 1, 0};
      int   sp_l [6] = '{0, 1, 1, 1, 0, 0};
      int   sp_d [6] = '{0, 0, 'h11, 'h22, 'h33, 0};
      int   sp_t [6] = '{0, 0, 0, 0, 1, 0};
      logic found;
      int   total;

      areset_i = 1'b1;
      tready_i = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("rst_tvalid", 32'(tvalid_o), 32'(0));
         check("rst_tdata", 32'(tdata_o), 32'(0));
         check("rst_tlast", 32'(tlast_o), 32'(0));
         check("rst_taddr", 32'(taddr_o), 32'(0));
         check("rst_tready", 32'(tready_o), 32'(0));
         check("rst_locked", 32'(locked_o), 32'(0));
         tready_i = 1'($urandom_range(1));
      end
      @(posedge clk); #3;
      rand_in  = 1'b0;
      tready_i = 1'b1;
      @(posedge clk); #3;
      areset_i = 1'b0;

      // First request after reset: 0 wins over 2.
      ord_q.push_back(0);
      ord_q.push_back(2);
      push_pkt(0, 1, 'h0100);
      push_pkt(2, 1, 'h0200);
      drain(50);

      // Single 3-beat packet from source 2, cycle-exact.
      @(posedge clk); #3;
      ord_q.push_back(2);
      push_beat(2, 'h11, 1'b0);
      push_beat(2, 'h22, 1'b0);
      push_beat(2, 'h33, 1'b1);
      @(negedge clk);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("sp_tvalid", 32'(tvalid_o), 32'(sp_v[k]));
         check("sp_locked", 32'(locked_o), 32'(sp_l[k]));
         if (sp_v[k] != 0) begin
            check("sp_tdata", 32'(tdata_o), 32'(sp_d[k]));
            check("sp_tlast", 32'(tlast_o), 32'(sp_t[k]));
            check("sp_taddr", 32'(taddr_o), 32'(2));
         end
      end
      drain(50);

      // Round robin from ptr 0 with all sources offering 1-beat packets.
      do_reset(2);
      @(posedge clk); #3;
      for (int p = 0; p < 2; p++)
         for (int s = 0; s < N; s++) begin
            push_pkt(s, 1, 'h0A00 + p * 16 + s);
            ord_q.push_back(s);
         end
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         found = tvalid_o;
      end
      if (!found) fail("rr_first_beat");
      else
         for (int k = 1; k < 15; k++) begin
            @(negedge clk);
            check("rr_bubble", 32'(tvalid_o), 32'(k % 2 == 0));
         end
      drain(50);

      // Packet lock: source 0 must wait for source 1's tlast, then wins.
      @(posedge clk); #3;
      ord_q.push_back(1);
      ord_q.push_back(0);
      ord_q.push_back(1);
      push_pkt(1, 4, 'h1100);
      push_pkt(1, 2, 'h1200);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(posedge clk); #3;
         found = (src_q[1].size() == 5);
      end
      if (!found) fail("lock_first_beat");
      push_pkt(0, 1, 'h0C00);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         check("lock_tready0", 32'(tready_o[0]), 32'(0));
         found = tvalid_i[1] & tready_o[1] & tlast_i[1];
      end
      if (!found) fail("lock_tlast");
      drain(80);

      // Backpressure: hold 0xAB for three cycles.
      @(posedge clk); #3;
      tready_i = 1'b0;
      ord_q.push_back(2);
      push_beat(2, 'hAB, 1'b0);
      push_beat(2, 'hAC, 1'b0);
      push_beat(2, 'hAD, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         found = tvalid_o;
      end
      if (!found) fail("bp_first_beat");
      else
         for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            check("bp_tdata", 32'(tdata_o), 32'('hAB));
            check("bp_tready", 32'(tready_o), 32'(0));
         end
      @(posedge clk); #3;
      tready_i = 1'b1;
      drain(50);

      // Reset after beat 2 of a 5-beat packet from source 3.
      @(posedge clk); #3;
      ord_q.push_back(3);
      push_pkt(3, 5, 'h3300);
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         @(posedge clk); #3;
         found = (src_q[3].size() == 3);
      end
      if (!found) fail("mid_rst_beat2");
      areset_i = 1'b1;
      clear_all();
      @(negedge clk);
      @(negedge clk);
      check("mid_rst_tvalid", 32'(tvalid_o), 32'(0));
      check("mid_rst_locked", 32'(locked_o), 32'(0));
      check("mid_rst_tready", 32'(tready_o), 32'(0));
      @(posedge clk); #3;
      areset_i = 1'b0;
      @(posedge clk); #3;
      ord_q.push_back(1);
      ord_q.push_back(3);
      push_pkt(1, 1, 'h1500);
      push_pkt(3, 1, 'h3500);
      drain(50);

      // Random traffic with bubbles and random downstream stalls.
      bubble_pct = 25;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #3;
         tready_i = ($urandom_range(3) != 0);
         if ($urandom_range(7) == 0)
            push_pkt(int'($urandom_range(N - 1)), int'($urandom_range(5, 1)), int'($urandom));
      end
      @(posedge clk); #3;
      bubble_pct = 0;
      tready_i   = 1'b1;
      drain(3000);
      total = 0;
      for (int s = 0; s < N; s++) total += exp_q[s].size();
      check("final_outstanding", 32'(total), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
